// File: rtl/traffic_light_timed_ctrl.sv
// traffic_light_timed_ctrl: timed highway/country light controller with
// minimum highway green, bounded country green, all-red clearance and emergency preempt.
module traffic_light_timed_ctrl #(
    parameter int CNT_W           = 8,
    parameter int MIN_HWY_GREEN   = 8,
    parameter int MAX_CNTRY_GREEN = 16,
    parameter int YELLOW          = 3,
    parameter int ALL_RED         = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             emerg,
    output logic [1:0]       hwy,
    output logic [1:0]       cntry,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] timer
);
    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] RED = 2'b01;
    localparam logic [1:0] YEL = 2'b10;

    localparam logic [CNT_W-1:0] L_HG  = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] L_CG  = CNT_W'(MAX_CNTRY_GREEN - 1);
    localparam logic [CNT_W-1:0] L_YEL = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] L_AR  = CNT_W'(ALL_RED - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, load;
    logic             tz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HG;
            timer_q <= L_HG;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        tz      = timer_q == '0;
        state_d = state_q;
        case (state_q)
            HG:      if (tz && x && !emerg) state_d = HY;
            HY:      if (tz) state_d = AR1;
            AR1:     if (tz) state_d = emerg ? HG : CG;
            CG:      if (!x || emerg || tz) state_d = CY;
            CY:      if (tz) state_d = AR2;
            AR2:     if (tz) state_d = HG;
            default: state_d = HG;
        endcase
        load    = (state_d == HY || state_d == CY) ? L_YEL :
                  (state_d == AR1 || state_d == AR2) ? L_AR :
                  (state_d == CG) ? L_CG : L_HG;
        // any state change (including escape from an unused code) reloads the timer
        timer_d = (state_d != state_q) ? load : (tz ? timer_q : timer_q - 1'b1);
    end

    assign hwy   = (state_q == HY) ? YEL :
                   (state_q == AR1 || state_q == CG || state_q == CY || state_q == AR2) ? RED : GRN;
    assign cntry = (state_q == CG) ? GRN : (state_q == CY) ? YEL : RED;
    assign phase = state_q;
    assign timer = timer_q;
endmodule
